// File: rtl/seg7_pkg.sv
// Shared definitions for the scrolling seven-segment driver: character codes,
// active-low segment patterns (bit6 = g .. bit0 = a) and the FSM state type.
package seg7_pkg;

   // Codes 0x00..0x0F are the hex digits themselves.
   localparam logic [4:0] CH_HEX_MAX = 5'h0F;
   localparam logic [4:0] CH_BLANK   = 5'h10;
   localparam logic [4:0] CH_DASH    = 5'h11;
   localparam logic [4:0] CH_U       = 5'h12;
   localparam logic [4:0] CH_L       = 5'h13;
   localparam logic [4:0] CH_T       = 5'h14;
   localparam logic [4:0] CH_R       = 5'h15;
   localparam logic [4:0] CH_N       = 5'h16;
   localparam logic [4:0] CH_I       = 5'h17;
   localparam logic [4:0] CH_O       = 5'h18;

   localparam logic [6:0] SEG_BLANK  = 7'h7F;
   localparam logic [6:0] SEG_U      = 7'b1000001;
   localparam logic [6:0] SEG_A      = 7'b0001000;
   localparam logic [6:0] SEG_E      = 7'b0000110;

   typedef enum logic {
      ST_IDLE,
      ST_SCROLL
   } state_t;

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational 5-bit character code to active-low segment pattern.
// Codes outside the table decode to blank.
module seg7_char_decode
   import seg7_pkg::*;
(
   input  logic [4:0] i_code,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_code)
         5'h00:    o_seg = 7'b1000000;
         5'h01:    o_seg = 7'b1111001;
         5'h02:    o_seg = 7'b0100100;
         5'h03:    o_seg = 7'b0110000;
         5'h04:    o_seg = 7'b0011001;
         5'h05:    o_seg = 7'b0010010;
         5'h06:    o_seg = 7'b0000010;
         5'h07:    o_seg = 7'b1111000;
         5'h08:    o_seg = 7'b0000000;
         5'h09:    o_seg = 7'b0010000;
         5'h0A:    o_seg = SEG_A;
         5'h0B:    o_seg = 7'b0000011;
         5'h0C:    o_seg = 7'b1000110;
         5'h0D:    o_seg = 7'b0100001;
         5'h0E:    o_seg = SEG_E;
         CH_HEX_MAX: o_seg = 7'b0001110;
         CH_BLANK: o_seg = SEG_BLANK;
         CH_DASH:  o_seg = 7'b0111111;
         CH_U:     o_seg = SEG_U;
         CH_L:     o_seg = 7'b1000111;
         CH_T:     o_seg = 7'b0000111;
         CH_R:     o_seg = 7'b0101111;
         CH_N:     o_seg = 7'b0101011;
         CH_I:     o_seg = 7'b1001111;
         CH_O:     o_seg = 7'b1000000;
         default:  o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_scroll_mux.sv
// Scrolling-message driver for a multiplexed common-anode seven-segment display.
// Optional blink input (forces blank on odd scroll positions) under SEG7_BLINK_EN.
module seg7_scroll_mux
   import seg7_pkg::*;
#(
   parameter int N_DIGITS   = 4,
   parameter int MAX_LEN    = 32,
   parameter int AW         = 5,
   parameter int SCROLL_DIV = 5000000,
   parameter int MUX_DIV    = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                activar,
`ifdef SEG7_BLINK_EN
   input  logic                blink,
`endif
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [4:0]          wr_data,
   input  logic [AW:0]         msg_len,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] an,
   output logic                step_pulse,
   output logic                busy
);

   localparam int LW = AW + 1;
   localparam int PW = AW + 2;
   localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [SW-1:0] STEP_LAST = SW'(SCROLL_DIV - 1);
   localparam logic [MW-1:0] MUX_LAST  = MW'(MUX_DIV - 1);
   localparam logic [DW-1:0] DIG_LAST  = DW'(N_DIGITS - 1);
   localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);

   state_t              r_state;
   logic [AW:0]         r_len;
   logic [PW-1:0]       r_pos;
   logic [SW-1:0]       r_step;
   logic [MW-1:0]       r_mux;
   logic [DW-1:0]       r_dig;
   logic [6:0]          r_seg;
   logic [N_DIGITS-1:0] r_an;
   logic                r_step_pulse;
   logic [4:0]          r_mem [MAX_LEN];

   logic [PW-1:0]       w_last_pos;
   logic [PW-1:0]       w_idx;
   logic [PW-1:0]       w_midx;
   logic [4:0]          w_code;
   logic [6:0]          w_seg;
   logic [N_DIGITS-1:0] w_an;
   logic                w_blank;

   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   // Stream index shown on the lit digit: N_DIGITS leading blanks, then the message.
   assign w_last_pos = PW'(r_len) + PW'(N_DIGITS - 1);
   assign w_idx      = r_pos + PW'(N_DIGITS - 1) - PW'(r_dig);
   assign w_midx     = w_idx - PW'(N_DIGITS);
   assign w_code     = (w_idx >= PW'(N_DIGITS) && w_midx < PW'(r_len)) ?
                       r_mem[w_midx[AW-1:0]] : CH_BLANK;
   assign w_an       = ~(N_DIGITS'(1) << r_dig);

`ifdef SEG7_BLINK_EN
   assign w_blank = blink & r_pos[0];
`else
   assign w_blank = 1'b0;
`endif

   seg7_char_decode u_dec (
      .i_code (w_code),
      .o_seg  (w_seg)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_pos        <= '0;
         r_step       <= '0;
         r_mux        <= '0;
         r_dig        <= '0;
         r_seg        <= SEG_BLANK;
         r_an         <= '1;
         r_step_pulse <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pos        <= '0;
               r_step       <= '0;
               r_mux        <= '0;
               r_dig        <= '0;
               r_seg        <= SEG_BLANK;
               r_an         <= '1;
               r_step_pulse <= 1'b0;
               if (activar && msg_len != '0) begin
                  r_state <= ST_SCROLL;
                  r_len   <= (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
               end
            end
            ST_SCROLL: begin
               if (!activar) begin
                  r_state      <= ST_IDLE;
                  r_pos        <= '0;
                  r_step       <= '0;
                  r_mux        <= '0;
                  r_dig        <= '0;
                  r_seg        <= SEG_BLANK;
                  r_an         <= '1;
                  r_step_pulse <= 1'b0;
               end else begin
                  r_seg <= w_blank ? SEG_BLANK : w_seg;
                  r_an  <= w_blank ? '1 : w_an;
                  if (r_step == STEP_LAST) begin
                     r_step       <= '0;
                     r_step_pulse <= 1'b1;
                     r_pos        <= (r_pos == w_last_pos) ? '0 : r_pos + 1'b1;
                  end else begin
                     r_step       <= r_step + 1'b1;
                     r_step_pulse <= 1'b0;
                  end
                  if (r_mux == MUX_LAST) begin
                     r_mux <= '0;
                     r_dig <= (r_dig == DIG_LAST) ? '0 : r_dig + 1'b1;
                  end else begin
                     r_mux <= r_mux + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign step_pulse = r_step_pulse;
   assign busy       = (r_state == ST_SCROLL);

endmodule

// File: tb/tb_seg7_scroll_mux.sv
// Randomised self-checking bench for seg7_scroll_mux against a time-based
// model of the scrolling stream (pos and digit derived from cycles since entry).
module tb_seg7_scroll_mux;

   localparam int N  = 4;
   localparam int ML = 32;
   localparam int AW = 5;
   localparam int SD = 8;
   localparam int MD = 2;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          activar = 1'b0;
   logic          wr_en   = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [4:0]    wr_data = '0;
   logic [AW:0]   msg_len = '0;
   logic [6:0]    seg;
   logic [N-1:0]  an;
   logic          step_pulse;
   logic          busy;
`ifdef SEG7_BLINK_EN
   logic          blink   = 1'b0;
`endif

   always #5 clk = ~clk;

   seg7_scroll_mux #(
      .N_DIGITS   (N),
      .MAX_LEN    (ML),
      .AW         (AW),
      .SCROLL_DIV (SD),
      .MUX_DIV    (MD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .activar    (activar),
`ifdef SEG7_BLINK_EN
      .blink      (blink),
`endif
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .msg_len    (msg_len),
      .seg        (seg),
      .an         (an),
      .step_pulse (step_pulse),
      .busy       (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model state
   logic [4:0] mem_m [ML];
   bit         m_act = 1'b0;
   int         m_k   = 0;
   int         m_len = 0;

   function automatic logic [6:0] ref_seg(input logic [4:0] c);
      case (c)
         5'h00: return 7'b1000000;
         5'h01: return 7'b1111001;
         5'h02: return 7'b0100100;
         5'h03: return 7'b0110000;
         5'h04: return 7'b0011001;
         5'h05: return 7'b0010010;
         5'h06: return 7'b0000010;
         5'h07: return 7'b1111000;
         5'h08: return 7'b0000000;
         5'h09: return 7'b0010000;
         5'h0A: return 7'b0001000;
         5'h0B: return 7'b0000011;
         5'h0C: return 7'b1000110;
         5'h0D: return 7'b0100001;
         5'h0E: return 7'b0000110;
         5'h0F: return 7'b0001110;
         5'h11: return 7'b0111111;
         5'h12: return 7'b1000001;
         5'h13: return 7'b1000111;
         5'h14: return 7'b0000111;
         5'h15: return 7'b0101111;
         5'h16: return 7'b0101011;
         5'h17: return 7'b1001111;
         5'h18: return 7'b1000000;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic logic [4:0] stream_at(input int i);
      if (i < N || i >= N + m_len) return 5'h10;
      return mem_m[i - N];
   endfunction

   // One clock: advance the model for the edge just taken, compare, then let
   // the write sampled on that edge land in the model memory.
   task automatic cycle();
      logic [6:0]   e_seg;
      logic [N-1:0] e_an;
      bit           e_sp;
      int           pos;
      int           dig;
      @(negedge clk);
      if (!m_act) begin
         if (activar && msg_len != 0) begin
            m_act = 1'b1;
            m_k   = 0;
            m_len = (int'(msg_len) > ML) ? ML : int'(msg_len);
         end
      end else if (!activar) begin
         m_act = 1'b0;
      end else begin
         m_k++;
      end
      e_seg = 7'h7F;
      e_an  = '1;
      e_sp  = 1'b0;
      if (m_act && m_k > 0) begin
         pos       = ((m_k - 1) / SD) % (m_len + N);
         dig       = ((m_k - 1) / MD) % N;
         e_an[dig] = 1'b0;
         e_seg     = ref_seg(stream_at(pos + N - 1 - dig));
         e_sp      = (m_k % SD == 0);
      end
      chk("seg", seg, e_seg);
      chk("an", an, e_an);
      chk("step_pulse", step_pulse, e_sp);
      chk("busy", busy, m_act);
      if (wr_en) mem_m[wr_addr] = wr_data;
      wr_en = 1'b0;
   endtask

   logic [4:0] uabc [4] = '{5'h12, 5'h0A, 5'h0B, 5'h0C};
   int         sp_cnt;
   bit         dash_seen;

   initial begin
      @(negedge clk);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_an", an, 4'hF);
      chk("rst_busy", busy, 1'b0);
      chk("rst_step", step_pulse, 1'b0);
      rst_n = 1'b1;

      for (int a = 0; a < ML; a++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(a);
         wr_data = (a < 4) ? uabc[a] : 5'($urandom_range(0, 31));
         cycle();
      end

      // Directed scroll of "UAbC" over one full pass and into the next
      msg_len = 4;
      activar = 1'b1;
      sp_cnt  = 0;
      for (int c = 0; c < 73; c++) begin
         cycle();
         if (m_k >= 1 && m_k <= 64 && step_pulse) sp_cnt++;
         case (m_k)
            9:  chk("scrollin_right_U", seg, 7'b1000001);
            11, 13, 15: chk("scrollin_blank", seg, 7'h7F);
            33: chk("pos4_C", seg, 7'b1000110);
            35: chk("pos4_b", seg, 7'b0000011);
            37: chk("pos4_A", seg, 7'b0001000);
            39: chk("pos4_U", seg, 7'b1000001);
            65, 67, 69, 71: chk("wrap_blank", seg, 7'h7F);
            default: ;
         endcase
      end
      chk("pulses_per_pass", sp_cnt, 8);

      // Disable mid-scroll and re-enable
      activar = 1'b0;
      cycle();
      chk("dis_an", an, 4'hF);
      chk("dis_busy", busy, 1'b0);
      repeat (3) cycle();
      activar = 1'b1;
      repeat (24) cycle();

      // Zero length stays idle
      activar = 1'b0;
      cycle();
      msg_len = 0;
      activar = 1'b1;
      repeat (10) cycle();
      chk("zero_len_busy", busy, 1'b0);
      chk("zero_len_an", an, 4'hF);

      // Live writes while msg[0] is in the window
      activar = 1'b0;
      cycle();
      msg_len = 4;
      activar = 1'b1;
      repeat (12) cycle();
      wr_en = 1'b1; wr_addr = 0; wr_data = 5'h11;
      cycle();
      wr_en = 1'b1; wr_addr = 1; wr_data = 5'h1F;
      cycle();
      dash_seen = 1'b0;
      repeat (12) begin
         cycle();
         if (seg == 7'b0111111) dash_seen = 1'b1;
      end
      chk("live_write_dash", dash_seen, 1'b1);

      // Randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 39) == 0) activar = ~activar;
         if ($urandom_range(0, 59) == 0) msg_len = (AW+1)'($urandom_range(0, 40));
         if ($urandom_range(0, 4) == 0) begin
            wr_en   = 1'b1;
            wr_addr = AW'($urandom_range(0, ML - 1));
            wr_data = 5'($urandom_range(0, 31));
         end
         cycle();
      end

      // Asynchronous reset mid-scroll
      activar = 1'b0;
      cycle();
      msg_len = 5;
      activar = 1'b1;
      repeat (30) cycle();
      chk("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_seg", seg, 7'h7F);
      chk("arst_an", an, 4'hF);
      chk("arst_busy", busy, 1'b0);
      chk("arst_step", step_pulse, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      m_act = 1'b0;
      repeat (40) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
